// File: rtl/nn_stream_loader_pkg.sv
// Shared definitions for the neural_net stream loader: FSM states, fp32 constants
// and the coefficient word-count helper.
package nn_stream_loader_pkg;

    localparam int FP_EXP_BIAS = 127;

    typedef enum logic [2:0] {
        LOAD_COEF = 3'd0,
        COLLECT   = 3'd1,
        KICK      = 3'd2,
        BURST_F   = 3'd3,
        BURST_C   = 3'd4
    } state_t;

    // Weights (n*m) followed by biases (m).
    function automatic int coef_words(input int n, input int m);
        return n * m + m;
    endfunction

endpackage

// File: rtl/nn_stream_loader_u8_to_fp32.sv
// Exact unsigned 8-bit pixel to fp32 conversion, scaled by 2^-SCALE_SHIFT.
// Every 8-bit value fits in the 24-bit significand, so no rounding is ever needed.
module u8_to_fp32
    import nn_stream_loader_pkg::*;
#(
    parameter int SCALE_SHIFT = 8
) (
    input  logic [7:0]  pix,
    output logic [31:0] fp
);

    logic [2:0]  msb;
    logic [4:0]  shamt;
    logic [7:0]  exp_val;
    logic [22:0] frac;

    always_comb begin
        msb = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pix[i]) begin
                msb = 3'(i);
            end
        end
        // Shifting the leading one to bit 23 drops it out of the 23-bit field (hidden bit).
        shamt   = 5'd23 - {2'b00, msb};
        frac    = {15'd0, pix} << shamt;
        exp_val = 8'(FP_EXP_BIAS + int'(msb) - SCALE_SHIFT);
        fp      = (pix == 8'd0) ? 32'd0 : {1'b0, exp_val, frac};
    end

endmodule

// File: rtl/nn_stream_loader.sv
// Feeds neural_net: holds coefficients loaded once, collects N pixels per frame, then
// pulses nn_rst and streams features, weights and biases back-to-back on nn_data.
module nn_stream_loader
    import nn_stream_loader_pkg::*;
#(
    parameter int N           = 3,
    parameter int M           = 2,
    parameter int SCALE_SHIFT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        coef_valid,
    output logic        coef_ready,
    input  logic [31:0] coef_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [7:0]  pix_data,
    output logic        nn_rst,
    output logic [31:0] nn_data,
    output logic        nn_valid,
    output logic        frame_done
);

    localparam int COEF_WORDS = coef_words(N, M);
    localparam int CW         = $clog2(N * M + M + 1);
    localparam int CA         = (COEF_WORDS > 1) ? $clog2(COEF_WORDS) : 1;
    localparam int FA         = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] COEF_LAST = CW'(COEF_WORDS - 1);
    localparam logic [CW-1:0] FEAT_LAST = CW'(N - 1);

    state_t        state, next_state;
    logic [CW-1:0] cidx, pidx, bcnt;
    logic [31:0]   coef_ram [COEF_WORDS];
    logic [31:0]   feat_ram [N];
    logic [31:0]   pix_fp;
    logic          coef_fire, pix_fire;
    logic          rd_en, rd_coef;
    logic [CA-1:0] c_addr;
    logic [FA-1:0] f_addr;

    assign coef_fire = coef_valid && coef_ready && (state == LOAD_COEF);
    assign pix_fire  = pix_valid && pix_ready && (state == COLLECT);

    u8_to_fp32 #(.SCALE_SHIFT(SCALE_SHIFT)) u_conv (
        .pix (pix_data),
        .fp  (pix_fp)
    );

    // The read issued in each cycle becomes next cycle's nn_data, so the fetch
    // always runs one word ahead of the output, including across the feature/coef seam.
    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        rd_coef    = 1'b0;
        c_addr     = '0;
        f_addr     = '0;
        case (state)
            LOAD_COEF: begin
                if (coef_fire && cidx == COEF_LAST) next_state = COLLECT;
            end
            COLLECT: begin
                if (pix_fire && pidx == FEAT_LAST) next_state = KICK;
            end
            KICK: begin
                next_state = BURST_F;
                rd_en      = 1'b1;
            end
            BURST_F: begin
                rd_en = 1'b1;
                if (bcnt == FEAT_LAST) begin
                    next_state = BURST_C;
                    rd_coef    = 1'b1;
                end else begin
                    f_addr = FA'(bcnt + 1'b1);
                end
            end
            BURST_C: begin
                if (bcnt == COEF_LAST) begin
                    next_state = COLLECT;
                end else begin
                    rd_en   = 1'b1;
                    rd_coef = 1'b1;
                    c_addr  = CA'(bcnt + 1'b1);
                end
            end
            default: next_state = LOAD_COEF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LOAD_COEF;
            cidx       <= '0;
            pidx       <= '0;
            bcnt       <= '0;
            coef_ready <= 1'b0;
            pix_ready  <= 1'b0;
            nn_rst     <= 1'b1;
            nn_data    <= 32'd0;
            nn_valid   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= next_state;
            coef_ready <= (next_state == LOAD_COEF);
            pix_ready  <= (next_state == COLLECT);
            nn_rst     <= (next_state == KICK);
            nn_valid   <= rd_en;
            frame_done <= (state == BURST_C) && (next_state == COLLECT);
            if (!rd_en)       nn_data <= 32'd0;
            else if (rd_coef) nn_data <= coef_ram[c_addr];
            else              nn_data <= feat_ram[f_addr];

            if (coef_fire) cidx <= (cidx == COEF_LAST) ? '0 : cidx + 1'b1;
            if (pix_fire)  pidx <= (pidx == FEAT_LAST) ? '0 : pidx + 1'b1;
            if (next_state != state)                      bcnt <= '0;
            else if (state == BURST_F || state == BURST_C) bcnt <= bcnt + 1'b1;
        end
    end

    // Coefficient RAM contents deliberately survive reset; only the index is cleared.
    always_ff @(posedge clk) begin
        if (!reset && coef_fire) coef_ram[CA'(cidx)] <= coef_data;
        if (!reset && pix_fire)  feat_ram[FA'(pidx)] <= pix_fp;
    end

endmodule
